fifo_uart_drain: RTL and testbench
==================================

FIFO_UART_DRAIN -- requirements
Module: fifo_uart_drain

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning FIFO word and UART character width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum clk_in cycles to wait for UART acceptance.
REQ-003 The block SHALL have parameter COUNT_BITS, default 16, meaning the width of the transmitted-byte counter.
REQ-004 The block SHALL have clk_in, input, width 1: the single clock, on which all state changes on the rising edge.
REQ-005 The block SHALL have n_rst, input, width 1: the reset, asynchronous and active-low.
REQ-006 The block SHALL have enable_in, input, width 1: permits the start of new transfers.
REQ-007 The block SHALL have clr_err_in, input, width 1: synchronous clear of timeout_err.
REQ-008 The block SHALL have fifo_empty_in, input, width 1: FIFO empty flag.
REQ-009 The block SHALL have fifo_rd_data_in, input, width DATA_BITS: FIFO read data, valid one cycle after fifo_rd_en.
REQ-010 The block SHALL have uart_tx_ready_in, input, width 1: UART transmitter idle, from the divided-clock logic.
REQ-011 The block SHALL have fifo_rd_en, output, width 1: FIFO read strobe.
REQ-012 The block SHALL have uart_tx_en, output, width 1: UART start request.
REQ-013 The block SHALL have uart_tx_data_out, output, width DATA_BITS: character to the transmitter.
REQ-014 The block SHALL have busy_out, output, width 1: high in every state except IDLE.
REQ-015 The block SHALL have tx_count_out, output, width COUNT_BITS: count of characters accepted by the UART.
REQ-016 The block SHALL have timeout_err, output, width 1: sticky acceptance-timeout flag.

Function
REQ-017 uart_tx_ready_in SHALL pass through a two-flop synchronizer (ready_s) before any use.
REQ-018 The FSM SHALL have the states IDLE, READ, CAPTURE, REQUEST and DRAIN.
REQ-019 IDLE SHALL go to READ when enable_in=1, fifo_empty_in=0 and ready_s=1; otherwise it SHALL stay in IDLE.
REQ-020 READ SHALL assert fifo_rd_en for exactly one cycle and then go to CAPTURE.
REQ-021 CAPTURE SHALL register fifo_rd_data_in into uart_tx_data_out and go to REQUEST.
REQ-022 REQUEST SHALL hold uart_tx_en=1 with uart_tx_data_out stable until ready_s=0 (acceptance), then deassert uart_tx_en and go to DRAIN.
REQ-023 DRAIN SHALL wait for ready_s=1 and then return to IDLE.
REQ-024 Latency SHALL be: fifo_rd_en at cycle N, data registered at N+1, uart_tx_en first high at N+2.
REQ-025 fifo_rd_en SHALL never assert while fifo_empty_in=1, and SHALL assert at most once per character.
REQ-026 tx_count_out SHALL increment by 1 on acceptance and SHALL wrap from all-ones to 0.
REQ-027 A timeout counter SHALL run in REQUEST; on reaching TIMEOUT_CYCLES-1 without acceptance the block SHALL deassert uart_tx_en, set timeout_err, drop the byte, leave the count unchanged, and return to IDLE.
REQ-028 timeout_err SHALL clear only on clr_err_in=1 or reset; when a set and a clear coincide, set SHALL win.
REQ-029 Deasserting enable_in mid-transfer SHALL let the current character complete; only new starts are blocked.
REQ-030 When the FIFO empties, the block SHALL idle without reading.

Reset
REQ-031 Reset SHALL force: state IDLE, fifo_rd_en=0, uart_tx_en=0, uart_tx_data_out=0, busy_out=0, tx_count_out=0, timeout_err=0, synchronizer flops=0, timeout counter=0.
REQ-032 Reset mid-REQUEST SHALL drop uart_tx_en immediately and not count the byte.

Structure
REQ-033 The state encoding and the DATA_BITS/COUNT_BITS defaults SHALL live in shared package fifo_uart_pkg.
REQ-034 The synchronizer SHALL be sub-module bit_sync (2-flop, reset to 0).

Verification
REQ-035 Bench case: FIFO holds 0x41,0x42,0x43, model UART accepts after 200 cycles -> three single-cycle rd pulses, bytes sent in order, tx_count_out=3, timeout_err=0.
REQ-036 Bench case: read 0x5A at cycle N -> uart_tx_en rises at N+2 with data 0x5A, held stable until ready_s falls.
REQ-037 Bench case: TIMEOUT_CYCLES=16, UART never accepts -> uart_tx_en drops after 16 cycles in REQUEST, timeout_err=1, count unchanged; clr_err_in pulse -> timeout_err=0.
REQ-038 Bench case: COUNT_BITS=4 with 17 bytes -> tx_count_out=1 after wrap.
REQ-039 Bench case: enable_in low during REQUEST with bytes queued -> current byte completes, no further fifo_rd_en.
REQ-040 Bench case: n_rst low during REQUEST -> all outputs at reset values asynchronously, no read on release with enable_in=0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-to-UART drain block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: drain FSM state encoding, default widths/timeout, timeout-counter width helper.
package fifo_uart_pkg;

  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_COUNT_BITS     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_REQUEST,
    ST_DRAIN
  } drain_state_t;

  // Width needed to count 0 .. cycles-1; never narrower than one bit.
  function automatic int tmo_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_drain_if.sv
// FIFO read port plus UART transmit port seen by the drain engine.
// Latency: n/a (wiring only).
// Backpressure: uart_tx_ready_in low holds off the engine; fifo_empty_in blocks reads.
// Ports: master = drain engine (drives fifo_rd_en, uart_tx_en, uart_tx_data_out);
//        slave  = FIFO/UART side (drives fifo_empty_in, fifo_rd_data_in, uart_tx_ready_in).
interface fifo_uart_drain_if
  import fifo_uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic                 fifo_empty_in;
  logic [DATA_BITS-1:0] fifo_rd_data_in;
  logic                 fifo_rd_en;
  logic                 uart_tx_ready_in;
  logic                 uart_tx_en;
  logic [DATA_BITS-1:0] uart_tx_data_out;

  modport master (
    input  fifo_empty_in,
    input  fifo_rd_data_in,
    input  uart_tx_ready_in,
    output fifo_rd_en,
    output uart_tx_en,
    output uart_tx_data_out
  );

  modport slave (
    output fifo_empty_in,
    output fifo_rd_data_in,
    output uart_tx_ready_in,
    input  fifo_rd_en,
    input  uart_tx_en,
    input  uart_tx_data_out
  );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single level signal from another clock domain.
// Latency: two clk_in rising edges from d_in to q_out.
// Backpressure: none.
// Ports: clk_in, n_rst (async active-low, clears both flops), d_in, q_out.
module bit_sync (
  input  logic clk_in,
  input  logic n_rst,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      q_out  <= 1'b0;
    end else begin
      meta_q <= d_in;
      q_out  <= meta_q;
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops one FIFO word at a time and hands it to a UART transmitter, counting accepted characters.
// Latency: fifo_rd_en at cycle N, data captured at N+1, uart_tx_en high from N+2 until acceptance.
// Backpressure: no new read until the synchronized UART ready is high; an unaccepted request times out.
// Ports: clk_in, n_rst (async active-low), enable_in (gates new starts), clr_err_in (clears timeout_err),
//        bus (FIFO read + UART tx handshake), busy_out, tx_count_out (wrapping), timeout_err (sticky).
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int COUNT_BITS     = DEF_COUNT_BITS
) (
  input  logic                  clk_in,
  input  logic                  n_rst,
  input  logic                  enable_in,
  input  logic                  clr_err_in,
  fifo_uart_drain_if.master     bus,
  output logic                  busy_out,
  output logic [COUNT_BITS-1:0] tx_count_out,
  output logic                  timeout_err
);

  localparam int            TW       = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  drain_state_t         state_q, state_d;
  logic                 ready_s;
  logic [TW-1:0]        tmo_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 accept;
  logic                 tmo_hit;
  logic                 rd_en;
  logic                 tx_en;

  // The UART ready comes from the divided-clock logic; never look at it raw.
  bit_sync u_ready_sync (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .d_in   (bus.uart_tx_ready_in),
    .q_out  (ready_s)
  );

  // Ready falling while we request is the UART's acceptance; it wins over a
  // timeout landing in the same cycle.
  assign accept  = (state_q == ST_REQUEST) && !ready_s;
  assign tmo_hit = (state_q == ST_REQUEST) && ready_s && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    tx_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // enable_in is only consulted here, so dropping it never aborts a character.
        if (enable_in && !bus.fifo_empty_in && ready_s) state_d = ST_READ;
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        tx_en = 1'b1;
        if (accept)       state_d = ST_DRAIN;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (ready_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data path, acceptance timer, character counter and sticky error.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      tx_data_q    <= '0;
      tmo_q        <= '0;
      tx_count_out <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (state_q == ST_CAPTURE) tx_data_q <= bus.fifo_rd_data_in;

      if ((state_q == ST_REQUEST) && (state_d == ST_REQUEST)) tmo_q <= tmo_q + TW'(1);
      else                                                    tmo_q <= '0;

      if (accept) tx_count_out <= tx_count_out + COUNT_BITS'(1);

      if (tmo_hit)         timeout_err <= 1'b1;
      else if (clr_err_in) timeout_err <= 1'b0;
    end
  end

  assign bus.fifo_rd_en       = rd_en;
  assign bus.uart_tx_en       = tx_en;
  assign bus.uart_tx_data_out = tx_data_q;
  assign busy_out             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: two instances (long timeout + 4-bit count, short timeout)
// driven by a queue-style FIFO model and a UART model with randomized acceptance delay.
// Expected values come from the pushed byte list and simple arithmetic on the rules.
module tb_fifo_uart_drain;

  localparam int BUSY_CYC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_n, en, clr;
  logic [1:0] rden, txen, busy, terr;
  logic [1:0] rdy = 2'b11;
  logic [7:0] rdd [2] = '{8'h00, 8'h00};
  logic [7:0] txd [2];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  // FIFO model: fmem holds everything pushed, in order; it is also the expected send order.
  logic [7:0] fmem [2][64];
  int fwr [2] = '{0, 0};
  int frd [2] = '{0, 0};

  // UART model state and log of accepted characters.
  int acc_lo [2];
  int acc_hi [2];
  bit never_acc [2];
  int ust [2] = '{0, 0};
  int ucnt [2] = '{0, 0};
  logic [7:0] sent [2][64];
  int nsent [2] = '{0, 0};

  // Monitor tallies.
  int rd_pulses [2] = '{0, 0};
  int rd_run_err [2] = '{0, 0};
  int rd_empty_err [2] = '{0, 0};
  int en_hi [2] = '{0, 0};
  int err_hi [2] = '{0, 0};
  int stab_err [2] = '{0, 0};
  int en_lat [2] = '{0, 0};
  int last_rd_cyc [2] = '{0, 0};
  int rd_age [2] = '{9, 9};
  logic [7:0] en_data [2] = '{8'h00, 8'h00};
  logic prev_rd [2] = '{1'b0, 1'b0};
  logic prev_en [2] = '{1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  fifo_uart_drain_if #(.DATA_BITS(8)) bus0 ();
  fifo_uart_drain_if #(.DATA_BITS(8)) bus1 ();

  assign bus0.fifo_empty_in    = (fwr[0] == frd[0]);
  assign bus0.fifo_rd_data_in  = rdd[0];
  assign bus0.uart_tx_ready_in = rdy[0];
  assign rden[0] = bus0.fifo_rd_en;
  assign txen[0] = bus0.uart_tx_en;
  assign txd[0]  = bus0.uart_tx_data_out;

  assign bus1.fifo_empty_in    = (fwr[1] == frd[1]);
  assign bus1.fifo_rd_data_in  = rdd[1];
  assign bus1.uart_tx_ready_in = rdy[1];
  assign rden[1] = bus1.fifo_rd_en;
  assign txen[1] = bus1.uart_tx_en;
  assign txd[1]  = bus1.uart_tx_data_out;

  fifo_uart_drain #(.DATA_BITS(8), .TIMEOUT_CYCLES(4096), .COUNT_BITS(4)) dut0 (
    .clk_in       (clk),
    .n_rst        (rst_n[0]),
    .enable_in    (en[0]),
    .clr_err_in   (clr[0]),
    .bus          (bus0),
    .busy_out     (busy[0]),
    .tx_count_out (cnt0),
    .timeout_err  (terr[0])
  );

  fifo_uart_drain #(.DATA_BITS(8), .TIMEOUT_CYCLES(16), .COUNT_BITS(16)) dut1 (
    .clk_in       (clk),
    .n_rst        (rst_n[1]),
    .enable_in    (en[1]),
    .clr_err_in   (clr[1]),
    .bus          (bus1),
    .busy_out     (busy[1]),
    .tx_count_out (cnt1),
    .timeout_err  (terr[1])
  );

  // FIFO + UART models and monitors, all evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (rden[c]) begin
          rd_pulses[c]++;
          if (prev_rd[c]) rd_run_err[c]++;
          last_rd_cyc[c] = cyc;
          rd_age[c] = 0;
          if (fwr[c] == frd[c]) begin
            rd_empty_err[c]++;
            rdd[c] = 'x;
          end else begin
            rdd[c] = fmem[c][frd[c] % 64];
            frd[c]++;
          end
        end else begin
          rd_age[c]++;
          if (rd_age[c] == 2) rdd[c] = 'x;
        end
        prev_rd[c] = rden[c];

        if (txen[c]) begin
          en_hi[c]++;
          if (!prev_en[c]) begin
            en_lat[c]  = cyc - last_rd_cyc[c];
            en_data[c] = txd[c];
          end else if (txd[c] !== en_data[c]) begin
            stab_err[c]++;
          end
        end
        prev_en[c] = txen[c];
        if (terr[c]) err_hi[c]++;

        case (ust[c])
          0: if (txen[c] && !never_acc[c]) begin
               ucnt[c] = int'($urandom_range(acc_hi[c], acc_lo[c])) - 1;
               ust[c] = 1;
             end
          1: if (!txen[c]) begin
               ust[c] = 0;
             end else if (ucnt[c] == 0) begin
               rdy[c] = 1'b0;
               sent[c][nsent[c] % 64] = txd[c];
               nsent[c]++;
               ucnt[c] = BUSY_CYC;
               ust[c] = 2;
             end else begin
               ucnt[c]--;
             end
          default: if (ucnt[c] == 0) begin
                     rdy[c] = 1'b1;
                     ust[c] = 0;
                   end else begin
                     ucnt[c]--;
                   end
        endcase
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] b);
    fmem[c][fwr[c] % 64] = b;
    fwr[c]++;
  endtask

  task automatic wait_idle(input int c, input int budget, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < budget) begin
      tick(1);
      n++;
      if (!busy[c] && ust[c] == 0 && rdy[c]) quiet++;
      else quiet = 0;
    end
    check({tag, "_settled"}, 32'(quiet >= 6), 32'd1);
  endtask

  task automatic wait_txen(input int c, input int budget, input string tag);
    int n = 0;
    while (!txen[c] && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_txen_seen"}, 32'(txen[c]), 32'd1);
  endtask

  initial begin
    int b_rd, b_sent, b_en, b_err;
    rst_n = 2'b00;
    en = 2'b00;
    clr = 2'b00;
    acc_lo = '{4, 4};
    acc_hi = '{12, 12};
    never_acc = '{1'b0, 1'b0};

    // Reset values while held in reset.
    #12;
    check("rst_rd_en0", 32'(rden[0]), 32'd0);
    check("rst_tx_en0", 32'(txen[0]), 32'd0);
    check("rst_data0", 32'(txd[0]), 32'd0);
    check("rst_busy0", 32'(busy[0]), 32'd0);
    check("rst_count0", 32'(cnt0), 32'd0);
    check("rst_err0", 32'(terr[0]), 32'd0);
    check("rst_tx_en1", 32'(txen[1]), 32'd0);
    check("rst_count1", 32'(cnt1), 32'd0);
    check("rst_err1", 32'(terr[1]), 32'd0);
    tick(3);
    rst_n = 2'b11;
    tick(4);

    // Three bytes, UART accepting 200 cycles after each request.
    acc_lo[0] = 200;
    acc_hi[0] = 200;
    b_rd = rd_pulses[0];
    b_sent = nsent[0];
    push(0, 8'h41);
    push(0, 8'h42);
    push(0, 8'h43);
    en[0] = 1'b1;
    wait_idle(0, 2000, "three");
    check("three_rd_pulses", 32'(rd_pulses[0] - b_rd), 32'd3);
    check("three_sent_n", 32'(nsent[0] - b_sent), 32'd3);
    for (int i = 0; i < 3; i++)
      check("three_order", 32'(sent[0][(b_sent + i) % 64]), 32'(8'h41 + i));
    check("three_count", 32'(cnt0), 32'd3);
    check("three_err", 32'(terr[0]), 32'd0);
    check("rd_single_cycle", 32'(rd_run_err[0]), 32'd0);
    check("rd_never_empty", 32'(rd_empty_err[0]), 32'd0);

    // Read-to-request latency and data stability.
    acc_lo[0] = 5;
    acc_hi[0] = 5;
    push(0, 8'h5A);
    wait_idle(0, 300, "lat");
    check("lat_rd_to_txen", 32'(en_lat[0]), 32'd2);
    check("lat_data", 32'(en_data[0]), 32'h5A);
    check("lat_data_stable", 32'(stab_err[0]), 32'd0);
    check("lat_count", 32'(cnt0), 32'd4);

    // Short timeout, UART never accepts.
    never_acc[1] = 1'b1;
    b_en = en_hi[1];
    b_rd = rd_pulses[1];
    push(1, 8'h99);
    en[1] = 1'b1;
    wait_idle(1, 300, "tmo");
    check("tmo_txen_cycles", 32'(en_hi[1] - b_en), 32'd16);
    check("tmo_err_set", 32'(terr[1]), 32'd1);
    check("tmo_count_same", 32'(cnt1), 32'd0);
    check("tmo_one_read", 32'(rd_pulses[1] - b_rd), 32'd1);
    check("tmo_nothing_sent", 32'(nsent[1]), 32'd0);
    tick(5);
    check("tmo_err_sticky", 32'(terr[1]), 32'd1);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    check("tmo_err_cleared", 32'(terr[1]), 32'd0);
    // Clear held high through a second timeout: the set must still show for a cycle.
    clr[1] = 1'b1;
    b_err = err_hi[1];
    push(1, 8'h66);
    wait_idle(1, 300, "tmo_clr");
    check("tmo_set_wins", 32'(err_hi[1] - b_err), 32'd1);
    check("tmo_err_after_clr", 32'(terr[1]), 32'd0);
    clr[1] = 1'b0;

    // Clear the count with a reset, then 17 random bytes through a 4-bit counter.
    en[0] = 1'b0;
    rst_n[0] = 1'b0;
    tick(2);
    check("wrap_count_reset", 32'(cnt0), 32'd0);
    rst_n[0] = 1'b1;
    tick(3);
    acc_lo[0] = 1;
    acc_hi[0] = 30;
    b_sent = nsent[0];
    for (int i = 0; i < 17; i++) push(0, 8'($urandom));
    en[0] = 1'b1;
    wait_idle(0, 3000, "wrap");
    check("wrap_count", 32'(cnt0), 32'd1);
    check("wrap_sent_n", 32'(nsent[0] - b_sent), 32'd17);
    for (int i = 0; i < 17; i++)
      check("wrap_order", 32'(sent[0][(b_sent + i) % 64]), 32'(fmem[0][(b_sent + i) % 64]));

    // enable_in dropped during a request with more bytes queued.
    acc_lo[0] = 20;
    acc_hi[0] = 20;
    b_rd = rd_pulses[0];
    b_sent = nsent[0];
    push(0, 8'h10);
    push(0, 8'h11);
    push(0, 8'h12);
    wait_txen(0, 50, "en_low");
    en[0] = 1'b0;
    wait_idle(0, 500, "en_low");
    tick(20);
    check("en_low_reads", 32'(rd_pulses[0] - b_rd), 32'd1);
    check("en_low_sent_n", 32'(nsent[0] - b_sent), 32'd1);
    check("en_low_byte", 32'(sent[0][b_sent % 64]), 32'h10);
    check("en_low_left", 32'(fwr[0] - frd[0]), 32'd2);
    check("en_low_count", 32'(cnt0), 32'd2);
    en[0] = 1'b1;
    wait_idle(0, 500, "en_resume");
    check("en_resume_count", 32'(cnt0), 32'd4);
    check("en_resume_sent_n", 32'(nsent[0] - b_sent), 32'd3);

    // Asynchronous reset in the middle of a request.
    acc_lo[0] = 100;
    acc_hi[0] = 100;
    push(0, 8'h77);
    push(0, 8'h78);
    wait_txen(0, 50, "arst");
    en[0] = 1'b0;
    tick(3);
    b_rd = rd_pulses[0];
    b_sent = nsent[0];
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("arst_tx_en", 32'(txen[0]), 32'd0);
    check("arst_rd_en", 32'(rden[0]), 32'd0);
    check("arst_data", 32'(txd[0]), 32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_count", 32'(cnt0), 32'd0);
    check("arst_err", 32'(terr[0]), 32'd0);
    tick(3);
    rst_n[0] = 1'b1;
    tick(30);
    check("arst_no_read", 32'(rd_pulses[0] - b_rd), 32'd0);
    check("arst_no_send", 32'(nsent[0] - b_sent), 32'd0);
    check("arst_idle", 32'(busy[0]), 32'd0);
    check("arst_count_after", 32'(cnt0), 32'd0);
    check("all_data_stable", 32'(stab_err[0] + stab_err[1]), 32'd0);
    check("all_rd_single", 32'(rd_run_err[0] + rd_run_err[1]), 32'd0);
    check("all_rd_not_empty", 32'(rd_empty_err[0] + rd_empty_err[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
